// File: rtl/neuron_mac_param.sv
// N_IN-channel fixed-point neuron: one multiply-accumulate per clock over a runtime-selected
// number of channels, then bias, saturation and a selectable activation.
module neuron_mac_param #(
    parameter int DATA_W = 32,
    parameter int FRAC   = 16,
    parameter int N_IN   = 7,
    parameter int AW     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_rdy,
    input  logic [N_IN*DATA_W-1:0]   data_in,
    input  logic [AW-1:0]            n_act,
    input  logic [1:0]               act_sel,
    input  logic                     w_we,
    input  logic [AW-1:0]            w_addr,
    input  logic [DATA_W-1:0]        w_wdata,
    output logic                     busy,
    output logic [DATA_W-1:0]        neu_out,
    output logic                     neu_rdy
);

    localparam int ACC_W = 2*DATA_W + AW;
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     next_state_s;
    logic                       in_rdy_q_r;
    logic                       start_s;
    logic                       idle_or_done_s;
    logic                       accept_s;
    logic [AW-1:0]              n_sat_s;
    logic [AW-1:0]              n_r;
    logic [AW-1:0]              cnt_r;
    logic [1:0]                 act_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [DATA_W-1:0]   x_r [N_IN];
    logic [DATA_W-1:0]          mem [N_IN+1];
    logic                       busy_r;
    logic                       neu_rdy_r;
    logic [DATA_W-1:0]          neu_out_r;

    logic signed [2*DATA_W-1:0] x_ext_s;
    logic signed [2*DATA_W-1:0] w_ext_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [SUM_W-1:0]    acc_ext_s;
    logic signed [SUM_W-1:0]    bias_sh_s;
    logic signed [SUM_W-1:0]    sum_s;
    logic signed [SUM_W-1:0]    shr_s;
    logic [DATA_W-1:0]          fin_val_s;

    // Clamp a wide signed value into the signed DATA_W range.
    function automatic logic [DATA_W-1:0] sat_word(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] max_v;
        logic signed [SUM_W-1:0] min_v;
        max_v = {{(SUM_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
        min_v = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
        if (v > max_v) begin
            sat_word = max_v[DATA_W-1:0];
        end else if (v < min_v) begin
            sat_word = min_v[DATA_W-1:0];
        end else begin
            sat_word = v[DATA_W-1:0];
        end
    endfunction

    // Activation on the saturated Q-format sum.
    function automatic logic [DATA_W-1:0] act_fn(input logic signed [DATA_W-1:0] s,
                                                 input logic [1:0] sel);
        logic signed [DATA_W-1:0] one_v;
        one_v = {{(DATA_W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
        case (sel)
            2'd1: begin
                if (s < 0) begin
                    act_fn = {DATA_W{1'b0}};
                end else begin
                    act_fn = s;
                end
            end
            2'd2: begin
                if (s < 0) begin
                    act_fn = {DATA_W{1'b0}};
                end else if (s > one_v) begin
                    act_fn = one_v;
                end else begin
                    act_fn = s;
                end
            end
            default: act_fn = s;
        endcase
    endfunction

    assign start_s        = in_rdy & ~in_rdy_q_r;
    assign idle_or_done_s = (state_r == S_IDLE) || (state_r == S_DONE);
    assign accept_s       = start_s & idle_or_done_s;
    assign n_sat_s        = (n_act > AW'(N_IN)) ? AW'(N_IN) : n_act;

    // State register and start edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            in_rdy_q_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            in_rdy_q_r <= in_rdy;
        end
    end

    // Next-state decode; starts arriving while busy are simply dropped.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (start_s) begin
                    next_state_s = (n_sat_s == {AW{1'b0}}) ? S_FIN : S_MAC;
                end else begin
                    next_state_s = state_r;
                end
            end
            S_MAC: begin
                if (cnt_r == n_r - AW'(1)) begin
                    next_state_s = S_FIN;
                end else begin
                    next_state_s = S_MAC;
                end
            end
            S_FIN:   next_state_s = S_DONE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Product, bias alignment and final result (bias is Q-format, so it is shifted up by FRAC).
    always_comb begin
        x_ext_s   = {{DATA_W{x_r[cnt_r][DATA_W-1]}}, x_r[cnt_r]};
        w_ext_s   = {{DATA_W{mem[cnt_r][DATA_W-1]}}, mem[cnt_r]};
        prod_s    = x_ext_s * w_ext_s;
        acc_ext_s = {acc_r[ACC_W-1], acc_r};
        bias_sh_s = {{(SUM_W-DATA_W){mem[N_IN][DATA_W-1]}}, mem[N_IN]} <<< FRAC;
        sum_s     = acc_ext_s + bias_sh_s;
        shr_s     = sum_s >>> FRAC;
        fin_val_s = act_fn(sat_word(shr_s), act_r);
    end

    // Operand capture and accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {AW{1'b0}};
            n_r   <= {AW{1'b0}};
            act_r <= 2'd0;
            for (int k = 0; k < N_IN; k++) begin
                x_r[k] <= {DATA_W{1'b0}};
            end
        end else if (accept_s) begin
            acc_r <= {ACC_W{1'b0}};
            cnt_r <= {AW{1'b0}};
            n_r   <= n_sat_s;
            act_r <= act_sel;
            for (int k = 0; k < N_IN; k++) begin
                x_r[k] <= data_in[k*DATA_W +: DATA_W];
            end
        end else if (state_r == S_MAC) begin
            acc_r <= acc_r + {{AW{prod_s[2*DATA_W-1]}}, prod_s};
            cnt_r <= cnt_r + AW'(1);
        end
    end

    // Registered outputs; neu_out only changes on the FIN edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r    <= 1'b0;
            neu_rdy_r <= 1'b0;
            neu_out_r <= {DATA_W{1'b0}};
        end else begin
            busy_r    <= (next_state_s == S_MAC) || (next_state_s == S_FIN);
            neu_rdy_r <= (next_state_s == S_DONE);
            if (state_r == S_FIN) begin
                neu_out_r <= fin_val_s;
            end
        end
    end

    // Weight/bias register file; intentionally not reset so preloaded contents survive.
    always_ff @(posedge clk) begin
        if (w_we && idle_or_done_s && (w_addr <= AW'(N_IN))) begin
            mem[w_addr] <= w_wdata;
        end
    end

    assign busy    = busy_r;
    assign neu_rdy = neu_rdy_r;
    assign neu_out = neu_out_r;

endmodule

// File: tb/tb_neuron_mac_param.sv
// Directed bench for neuron_mac_param: vector table plus hand-written multi-cycle sequences.
module tb_neuron_mac_param;

    localparam int DATA_W = 32;
    localparam int N_IN   = 7;
    localparam int AW     = 3;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_rdy;
    logic [N_IN*DATA_W-1:0] data_in;
    logic [AW-1:0]          n_act;
    logic [1:0]             act_sel;
    logic                   w_we;
    logic [AW-1:0]          w_addr;
    logic [DATA_W-1:0]      w_wdata;
    logic                   busy;
    logic [DATA_W-1:0]      neu_out;
    logic                   neu_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        logic [31:0]  w;
        logic [31:0]  b;
        logic [31:0]  x;
        logic [2:0]   n;
        logic [1:0]   sel;
        logic [31:0]  exp_out;
        int           exp_lat;
    } vec_t;

    vec_t vecs [11];

    neuron_mac_param #(.DATA_W(32), .FRAC(16), .N_IN(7), .AW(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_rdy  (in_rdy),
        .data_in (data_in),
        .n_act   (n_act),
        .act_sel (act_sel),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_wdata (w_wdata),
        .busy    (busy),
        .neu_out (neu_out),
        .neu_rdy (neu_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int addr, input logic [31:0] data);
        w_we    = 1'b1;
        w_addr  = 3'(addr);
        w_wdata = data;
        tick();
        w_we    = 1'b0;
    endtask

    task automatic load(input logic [31:0] w, input logic [31:0] b, input logic [31:0] x,
                        input logic [2:0] n, input logic [1:0] sel);
        for (int k = 0; k < N_IN; k++) begin
            write_w(k, w);
        end
        write_w(N_IN, b);
        for (int k = 0; k < N_IN; k++) begin
            data_in[k*DATA_W +: DATA_W] = x;
        end
        n_act   = n;
        act_sel = sel;
    endtask

    // Produce a fresh rising edge of in_rdy, then count cycles until neu_rdy (bounded).
    task automatic run(input string name, output int lat, output logic [31:0] out);
        in_rdy = 1'b0;
        tick();
        in_rdy = 1'b1;
        tick();
        check({name, "_accept_busy"}, {31'd0, busy}, 32'd1);
        check({name, "_accept_rdy_clr"}, {31'd0, neu_rdy}, 32'd0);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (neu_rdy) break;
        end
        out = neu_out;
    endtask

    initial begin
        int          lat;
        logic [31:0] out;
        int          rises;
        int          rise_at;
        logic        prev;
        int          busy_cnt;
        int          drop_cnt;

        vecs[0]  = '{"id_sum",     32'h0001_0000, 32'h0000_0000, 32'h0002_0000, 3'd7, 2'd0, 32'h000E_0000, 8};
        vecs[1]  = '{"relu_neg",   32'h0001_0000, 32'hFFF0_0000, 32'h0002_0000, 3'd7, 2'd1, 32'h0000_0000, 8};
        vecs[2]  = '{"id_neg",     32'h0001_0000, 32'hFFF0_0000, 32'h0002_0000, 3'd7, 2'd0, 32'hFFFE_0000, 8};
        vecs[3]  = '{"clamp_hi",   32'h0001_0000, 32'h0000_0000, 32'h0002_0000, 3'd7, 2'd2, 32'h0001_0000, 8};
        vecs[4]  = '{"clamp_lo",   32'h0001_0000, 32'hFFF0_0000, 32'h0002_0000, 3'd7, 2'd2, 32'h0000_0000, 8};
        vecs[5]  = '{"sat_pos",    32'h7FFF_FFFF, 32'h0000_0000, 32'h7FFF_FFFF, 3'd7, 2'd0, 32'h7FFF_FFFF, 8};
        vecs[6]  = '{"sat_neg",    32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0001, 3'd7, 2'd0, 32'h8000_0000, 8};
        vecs[7]  = '{"n0_bias",    32'h0001_0000, 32'h0003_0000, 32'h0002_0000, 3'd0, 2'd0, 32'h0003_0000, 1};
        vecs[8]  = '{"n3",         32'h0001_0000, 32'h0000_0000, 32'h0002_0000, 3'd3, 2'd0, 32'h0006_0000, 4};
        vecs[9]  = '{"trunc_ninf", 32'h0000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 3'd1, 2'd0, 32'hFFFF_FFFF, 2};
        vecs[10] = '{"sel3_id",    32'h0001_0000, 32'h0000_0000, 32'h0002_0000, 3'd7, 2'd3, 32'h000E_0000, 8};

        reset   = 1'b0;
        in_rdy  = 1'b0;
        data_in = '0;
        n_act   = 3'd0;
        act_sel = 2'd0;
        w_we    = 1'b0;
        w_addr  = 3'd0;
        w_wdata = 32'd0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy", {31'd0, neu_rdy}, 32'd0);
        check("rst_out", neu_out, 32'd0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            load(vecs[i].w, vecs[i].b, vecs[i].x, vecs[i].n, vecs[i].sel);
            run(vecs[i].name, lat, out);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({vecs[i].name, "_out"}, out, vecs[i].exp_out);
        end

        // in_rdy held high after the result: no further computation.
        load(32'h0001_0000, 32'h0, 32'h0002_0000, 3'd7, 2'd0);
        run("hold", lat, out);
        busy_cnt = 0;
        drop_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (busy) busy_cnt++;
            if (!neu_rdy) drop_cnt++;
        end
        check("hold_no_restart_busy", 32'(busy_cnt), 32'd0);
        check("hold_rdy_kept", 32'(drop_cnt), 32'd0);
        check("hold_out", neu_out, 32'h000E_0000);

        // Weight write and second start edge while busy are both ignored.
        in_rdy = 1'b0;
        tick();
        in_rdy = 1'b1;
        tick();
        w_we    = 1'b1;
        w_addr  = 3'd0;
        w_wdata = 32'h0005_0000;
        in_rdy  = 1'b0;
        tick();
        w_we   = 1'b0;
        in_rdy = 1'b1;
        tick();
        rises   = 0;
        rise_at = -1;
        prev    = neu_rdy;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (neu_rdy && !prev) begin
                rises++;
                if (rise_at < 0) rise_at = c;
            end
            prev = neu_rdy;
        end
        check("busy_one_rdy", 32'(rises), 32'd1);
        check("busy_rdy_cycle", 32'(rise_at), 32'd6);
        check("busy_out", neu_out, 32'h000E_0000);
        run("after_busy_wr", lat, out);
        check("after_busy_wr_out", out, 32'h000E_0000);

        // Reset in the middle of MAC.
        in_rdy = 1'b0;
        tick();
        in_rdy = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rdy", {31'd0, neu_rdy}, 32'd0);
        check("midrst_out", neu_out, 32'd0);
        in_rdy = 1'b0;
        tick();
        check("midrst_no_pulse", {31'd0, neu_rdy}, 32'd0);
        reset = 1'b1;
        run("post_rst", lat, out);
        check("post_rst_lat", 32'(lat), 32'd8);
        check("post_rst_out", out, 32'h000E_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/neuron_mac_param.md
Name: neuron_mac_param

Overview:
- Parametrised successor to the fixed 7-input neuron: N_IN-channel fixed-point neuron with a runtime-selectable active input count, bias and activation.
- One multiply-accumulate per clock.
- Weights and bias live in an internal register file, loadable through a write port as well as by $readmemb.
- Sits in the hidden/output layer datapath between the input staging registers and the next layer's in_rdy.

Parameters:
- DATA_W, 32: signed word width of inputs, weights, bias and output.
- FRAC, 16: fractional bits (signed Q(DATA_W-FRAC).FRAC).
- N_IN, 7: maximum input channels.
- AW, 3: weight address width; must satisfy 2^AW >= N_IN+1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_rdy  in  1  start request; only a rising edge is acted on.
- data_in  in  N_IN*DATA_W  input vector, channel k at [k*DATA_W +: DATA_W].
- n_act  in  AW  active channel count, 0..N_IN.
- act_sel  in  2  activation: 0 identity, 1 ReLU, 2 clamp to [0, 1.0], 3 same as identity.
- w_we  in  1  weight write enable.
- w_addr  in  AW  0..N_IN-1 = weight k; N_IN = bias.
- w_wdata  in  DATA_W  weight/bias write data.
- busy  out  1  computation in progress.
- neu_out  out  DATA_W  result.
- neu_rdy  out  1  neu_out valid.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; busy=0, neu_rdy=0, neu_out=0; accumulator, counter and edge register cleared.
  - Weight memory (instance name mem, depth N_IN+1) is not cleared.
- Start detection:
  - in_rdy_q registers in_rdy.
  - start = in_rdy & ~in_rdy_q, evaluated every cycle.
  - start is honoured only in IDLE or DONE. A start seen while busy is dropped and does not queue.
  - in_rdy held high after the first edge causes no further computations.
- Accept edge E0:
  - data_in, n_act (saturated to N_IN if larger) and act_sel are captured.
  - acc=0, cnt=0, busy=1, neu_rdy=0, state=MAC (or FIN directly if n_act=0).
- MAC, edges E1..En (n = captured n_act):
  - acc += x[cnt]*mem[cnt], full 2*DATA_W-bit signed product; cnt++.
  - Leave to FIN after cnt reaches n-1.
  - Accumulator width 2*DATA_W + AW; no overflow is possible inside it.
- FIN, edge E(n+1):
  - s = (acc + (mem[N_IN] <<< FRAC)) >>> FRAC, arithmetic shift, truncation toward -inf.
  - s saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Activation applied to s.
  - neu_out registered; neu_rdy=1; busy=0; state=DONE.
- Latency: neu_rdy is high after edge E(n_act+1). n_act=7 gives 8 cycles after accept; n_act=0 gives 1 cycle, with neu_out = act(bias).
- DONE:
  - neu_out and neu_rdy held until the next accepted start. That start clears neu_rdy at its accept edge.
  - neu_out holds its old value until the next FIN.
- Weight writes:
  - Accepted when w_we=1 and state is IDLE or DONE; mem[w_addr] is updated at the edge.
  - Writes while busy, or with w_addr > N_IN, are ignored.
  - A write on the same edge as an accepted start takes effect before the first MAC.
- Data stability: data_in may change after E0, since values are captured. Weights must not be relied on to change mid-computation; writes are blocked while busy.
- Reset mid-MAC: immediate return to IDLE; no neu_rdy pulse; a subsequent rising edge of in_rdy starts a fresh computation.

Test Plan:
1. Reset, write weights 0..6 = 0x00010000 (1.0) and bias 0, data_in all 0x00020000 (2.0), n_act=7, act_sel=0, raise in_rdy and hold it high.
   - neu_rdy rises 8 cycles after the accept edge with neu_out=0x000E0000.
   - No second computation occurs while in_rdy stays high.
2. Same weights, bias = 0xFFF00000 (-16.0), act_sel=1.
   - Identity result would be -2.0; ReLU gives neu_out=0.
   - With act_sel=2 and bias=0, neu_out=0x00010000 (clamped from 14.0).
3. Weights 0x7FFFFFFF, inputs 0x7FFFFFFF, n_act=7, act_sel=0.
   - neu_out=0x7FFFFFFF (positive saturation).
   - Negate all inputs: neu_out=0x80000000.
4. n_act=0, bias=0x00030000.
   - neu_rdy 1 cycle after accept; neu_out=0x00030000.
   - n_act=3 with scenario-1 data gives 0x00060000 after 4 cycles.
5. Weight write issued while busy.
   - Ignored: the result matches the pre-write weights.
   - A second in_rdy rising edge while busy is dropped: exactly one neu_rdy assertion.
6. Assert reset during MAC cycle 3.
   - busy=0, neu_rdy=0, neu_out=0 immediately; weights retained.
   - The next in_rdy rising edge reproduces the scenario-1 result.
